// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: EX forwarding,
// load-use stall, branch flush, data-memory freeze with watchdog, perf counters.
module hazard_ctrl #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_d_i,
  input  logic [REG_AW-1:0] rs2_d_i,
  input  logic [REG_AW-1:0] rs1_e_i,
  input  logic [REG_AW-1:0] rs2_e_i,
  input  logic [REG_AW-1:0] rd_e_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              regwrite_m_i,
  input  logic              regwrite_w_i,
  input  logic              load_e_i,
  input  logic              pcsrc_e_i,
  input  logic              mem_busy_i,
  input  logic              clr_i,
  output logic              stall_f_o,
  output logic              stall_d_o,
  output logic              stall_e_o,
  output logic              stall_m_o,
  output logic              flush_d_o,
  output logic              flush_e_o,
  output logic [1:0]        fwd_a_e_o,
  output logic [1:0]        fwd_b_e_o,
  output logic              mem_wait_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic              err_timeout_o
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [0:0]  S_RUN  = 1'b0;
  localparam logic [0:0]  S_WAIT = 1'b1;

  logic [0:0]        state, stateNext;
  logic [WCNT_W-1:0] waitCnt, waitCntNext;
  logic              errSet;
  logic              lwHz;
  logic              stallAny;
  logic              flushEvt;

  // M result wins over W; x0 is never a forwarding source.
  function automatic logic [1:0] fwdSel(
    input logic [REG_AW-1:0] rs,
    input logic              wrM,
    input logic [REG_AW-1:0] rdM,
    input logic              wrW,
    input logic [REG_AW-1:0] rdW
  );
    if (wrM && (rdM != '0) && (rdM == rs)) return 2'b10;
    if (wrW && (rdW != '0) && (rdW == rs)) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    fwd_a_e_o = 2'b00;
    fwd_b_e_o = 2'b00;
    if (rst_n) begin
      fwd_a_e_o = fwdSel(rs1_e_i, regwrite_m_i, rd_m_i, regwrite_w_i, rd_w_i);
      fwd_b_e_o = fwdSel(rs2_e_i, regwrite_m_i, rd_m_i, regwrite_w_i, rd_w_i);
    end
  end

  assign lwHz = load_e_i && (rd_e_i != '0) && ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));

  // Freeze beats redirect beats load-use; reset forces bubbles everywhere.
  always_comb begin
    stall_f_o = 1'b0;
    stall_d_o = 1'b0;
    stall_e_o = 1'b0;
    stall_m_o = 1'b0;
    flush_d_o = 1'b0;
    flush_e_o = 1'b0;
    if (!rst_n) begin
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
    end else if (mem_busy_i) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      stall_e_o = 1'b1;
      stall_m_o = 1'b1;
    end else if (pcsrc_e_i) begin
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
    end else if (lwHz) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      flush_e_o = 1'b1;
    end
  end

  assign stallAny = stall_f_o | stall_d_o | stall_e_o | stall_m_o;
  assign flushEvt = rst_n && !mem_busy_i && pcsrc_e_i;

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    errSet      = 1'b0;
    case (state)
      S_RUN: begin
        if (mem_busy_i) begin
          stateNext   = S_WAIT;
          waitCntNext = WCNT_W'(1);
        end
      end
      S_WAIT: begin
        if (!mem_busy_i) begin
          stateNext   = S_RUN;
          waitCntNext = '0;
        end else begin
          if (waitCnt == WCNT_W'(TIMEOUT - 1)) errSet = 1'b1;
          if (waitCnt != WCNT_W'(TIMEOUT)) waitCntNext = waitCnt + WCNT_W'(1);
        end
      end
      default: begin
        stateNext   = S_RUN;
        waitCntNext = '0;
      end
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_RUN;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  assign mem_wait_o = (state == S_WAIT);

  // Clear outranks any same-cycle increment or watchdog set.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o   <= '0;
      flush_cnt_o   <= '0;
      err_timeout_o <= 1'b0;
    end else if (clr_i) begin
      stall_cnt_o   <= '0;
      flush_cnt_o   <= '0;
      err_timeout_o <= 1'b0;
    end else begin
      if (stallAny && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (flushEvt && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      if (errSet) err_timeout_o <= 1'b1;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipelined RISC-V core.
- Adds three things the current pipeline lacks:
  - EX-stage operand forwarding from M and W.
  - Load-use stall plus bubble insertion.
  - Taken-branch/jump flush, a multi-cycle data-memory freeze, and a timeout watchdog.
- Sits beside the pipeline registers; drives their stall/flush enables and the EX operand muxes.
- Keeps saturating stall/flush performance counters.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of performance counters.
- TIMEOUT, 64, consecutive mem-busy cycles before the watchdog error is set (minimum 2).

Ports:
- clk  in  1  clock; all state updates on negedge clk, matching the pipeline registers.
- rst_n  in  1  asynchronous, active-low reset.
- rs1_d_i, rs2_d_i  in  REG_AW  source registers of the instruction in D.
- rs1_e_i, rs2_e_i, rd_e_i  in  REG_AW  source and destination registers in E.
- rd_m_i, rd_w_i  in  REG_AW  destination registers in M and W.
- regwrite_m_i, regwrite_w_i  in  1  register-write enables in M and W.
- load_e_i  in  1  instruction in E is a load (ResultSrcE).
- pcsrc_e_i  in  1  taken branch or jump resolved in E.
- mem_busy_i  in  1  data memory not ready; whole pipeline must hold.
- clr_i  in  1  synchronous clear of counters and error.
- stall_f_o, stall_d_o, stall_e_o, stall_m_o  out  1  hold enables for the F, D, E and M registers.
- flush_d_o, flush_e_o  out  1  bubble insertion into the D and E registers.
- fwd_a_e_o, fwd_b_e_o  out  2  EX operand select: 00 register file, 01 W result, 10 M ALU result.
- mem_wait_o  out  1  FSM is in WAIT.
- stall_cnt_o, flush_cnt_o  out  CNT_W  saturating counters.
- err_timeout_o  out  1  sticky watchdog error.

Behaviour:
- Forwarding (combinational, per operand; A shown, B identical with rs2_e_i):
  - 10 if regwrite_m_i && rd_m_i!=0 && rd_m_i==rs1_e_i.
  - else 01 if regwrite_w_i && rd_w_i!=0 && rd_w_i==rs1_e_i.
  - else 00.
  - M has priority over W. x0 is never forwarded.
- lw_hz = load_e_i && rd_e_i!=0 && (rd_e_i==rs1_d_i || rd_e_i==rs2_d_i).
- Output priority (combinational, highest first):
  1. mem_busy_i=1: stall_f/d/e/m=1, all flushes 0; pcsrc_e_i and lw_hz are ignored that cycle. E is held, so a pending redirect is re-seen once busy drops.
  2. pcsrc_e_i=1: flush_d=flush_e=1, all stalls 0.
  3. lw_hz=1: stall_f=stall_d=1, flush_e=1, stall_e=stall_m=0. This gives exactly one bubble, because the load reaches M next cycle and is then forwarded from W.
  4. Otherwise all 0.
- FSM (negedge clk):
  - RUN: if mem_busy_i go to WAIT with wait_cnt<=1; else stay.
  - WAIT: if !mem_busy_i go to RUN with wait_cnt<=0; else wait_cnt<=wait_cnt+1, saturating at TIMEOUT.
  - If wait_cnt==TIMEOUT-1 while busy in WAIT, set err_timeout_o (sticky). The freeze continues regardless.
- Counters:
  - stall_cnt_o +1 on every cycle any stall_*_o is 1.
  - flush_cnt_o +1 on every cycle case 2 applies.
  - Both saturate at all-ones and never wrap.
  - clr_i zeroes both counters and err_timeout_o. clr_i has priority over increment in the same cycle; FSM state is unaffected.
- Reset (rst_n=0, async): state=RUN, wait_cnt=0, counters=0, err_timeout_o=0, mem_wait_o=0.
  - While in reset: flush_d_o=flush_e_o=1, all stalls 0, fwd=00, irrespective of inputs.
  - Reset asserted mid-WAIT aborts the wait immediately; the first negedge after release evaluates from RUN.
- Latency:
  - Forwarding, stall and flush outputs are zero-latency combinational.
  - mem_wait_o, counters and error update at the negedge after the causing condition.

Test Plan:
- rd_m=5, regwrite_m=1, rd_w=5, regwrite_w=1, rs1_e=5, rs2_e=0 -> fwd_a=10, fwd_b=00. Then set rd_m=3 -> fwd_a=01. Then rd_w=0, rs1_e=0 -> fwd_a=00.
- load_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 for exactly one cycle, stall_cnt 0->1. Repeat with rd_e=0 -> no stall.
- pcsrc_e=1 together with lw_hz conditions -> flush_d=flush_e=1, stalls 0, flush_cnt increments by 1.
- mem_busy_i high for 3 cycles with pcsrc_e=1 -> 3 freeze cycles with no flush, mem_wait_o=1, stall_cnt +3. On busy low, flush fires once and mem_wait_o returns to 0.
- TIMEOUT=4, mem_busy_i held 6 cycles -> err_timeout_o set after 4th busy cycle and stays set after busy drops. clr_i pulse -> err 0, counters 0.
- Assert rst_n=0 mid-WAIT -> flushes 1, stalls 0, mem_wait_o 0 immediately. Release with mem_busy_i=0 -> FSM in RUN, counters 0. Also preload stall_cnt to all-ones -> stays all-ones on a further stall.
